// File: rtl/game_tick_scheduler.sv
// Four-channel programmable tick scheduler for game timing.
// Each channel divides the system clock by its own divisor and emits a one-cycle
// tick pulse plus a square wave that toggles on every tick. A small run/pause/idle
// controller gates all channels, and divisor writes made while running are parked
// in a single pending slot until the target channel's next tick.
module game_tick_scheduler #(
  parameter int unsigned W    = 32,
  parameter int unsigned DIV0 = 833333,
  parameter int unsigned DIV1 = 5000000,
  parameter int unsigned DIV2 = 25000000,
  parameter int unsigned DIV3 = 50000000
) (
  input  logic         cin,
  input  logic         reset,
  input  logic         start,
  input  logic         pause,
  input  logic         stop,
  input  logic         cfg_valid,
  input  logic [1:0]   cfg_sel,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic [3:0]   tick,
  output logic [3:0]   sq,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10
  } state_e;

  state_e         state_q, state_d;

  logic [W-1:0]   div_q [4];
  logic [W-1:0]   div_d [4];
  logic [W-1:0]   cnt_q [4];
  logic [W-1:0]   cnt_d [4];
  logic [3:0]     tick_q, tick_d;
  logic [3:0]     sq_q, sq_d;

  logic           pend_valid_q, pend_valid_d;
  logic [1:0]     pend_sel_q, pend_sel_d;
  logic [W-1:0]   pend_div_q, pend_div_d;

  // Terminal count per channel; a zero divisor behaves as a divisor of one.
  logic [W-1:0]   last_cnt [4];
  // Channel reaches its terminal count on this edge (only meaningful in RUN).
  logic [3:0]     hit;

  // Terminal-count compare; >= keeps a counter from running past a shrunken divisor.
  always_comb begin
    hit = '0;
    for (int i = 0; i < 4; i++) begin
      last_cnt[i] = (div_q[i] == '0) ? '0 : div_q[i] - W'(1);
      hit[i]      = (cnt_q[i] >= last_cnt[i]);
    end
  end

  // Run/pause/idle controller; stop beats pause beats start.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = StIdle;
    end else if (pause) begin
      if (state_q == StRun) begin
        state_d = StPause;
      end
    end else if (start) begin
      if (state_q == StIdle || state_q == StPause) begin
        state_d = StRun;
      end
    end
  end

  // Channel counters, pending-divisor slot and write acceptance.
  always_comb begin
    div_d        = div_q;
    cnt_d        = cnt_q;
    sq_d         = sq_q;
    tick_d       = '0;
    pend_valid_d = pend_valid_q;
    pend_sel_d   = pend_sel_q;
    pend_div_d   = pend_div_q;

    // Counters act on the state being left; the new state applies from the next edge.
    unique case (state_q)
      StRun: begin
        for (int i = 0; i < 4; i++) begin
          if (hit[i]) begin
            tick_d[i] = 1'b1;
            sq_d[i]   = ~sq_q[i];
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i]  = cnt_q[i] + W'(1);
          end
        end
      end
      StPause: begin
        // Counts and square waves hold so a resume loses no phase.
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          cnt_d[i] = '0;
        end
        sq_d = '0;
      end
    endcase

    // Drain the pending slot: immediately when leaving/outside RUN, else on the
    // target channel's tick (which still fires under the old divisor).
    if (pend_valid_q) begin
      if (stop || pause || state_q != StRun) begin
        div_d[pend_sel_q] = pend_div_q;
        cnt_d[pend_sel_q] = '0;
        pend_valid_d      = 1'b0;
      end else if (hit[pend_sel_q]) begin
        div_d[pend_sel_q] = pend_div_q;
        pend_valid_d      = 1'b0;
      end
    end

    // New writes follow the rules of the state being left.
    if (cfg_valid && !pend_valid_q) begin
      if (state_q == StRun) begin
        pend_valid_d = 1'b1;
        pend_sel_d   = cfg_sel;
        pend_div_d   = cfg_div;
      end else begin
        div_d[cfg_sel] = cfg_div;
        cnt_d[cfg_sel] = '0;
      end
    end

    // Entering IDLE clears everything on the same edge.
    if (stop) begin
      for (int i = 0; i < 4; i++) begin
        cnt_d[i] = '0;
      end
      tick_d = '0;
      sq_d   = '0;
    end
  end

  // State register with synchronous reset to the parameter divisors.
  always_ff @(posedge cin) begin
    if (reset) begin
      state_q      <= StIdle;
      div_q[0]     <= W'(DIV0);
      div_q[1]     <= W'(DIV1);
      div_q[2]     <= W'(DIV2);
      div_q[3]     <= W'(DIV3);
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      tick_q       <= '0;
      sq_q         <= '0;
      pend_valid_q <= 1'b0;
      pend_sel_q   <= '0;
      pend_div_q   <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      sq_q         <= sq_d;
      pend_valid_q <= pend_valid_d;
      pend_sel_q   <= pend_sel_d;
      pend_div_q   <= pend_div_d;
    end
  end

  assign cfg_ready = ~pend_valid_q;
  assign tick      = tick_q;
  assign sq        = sq_q;
  assign state     = state_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler: directed scenarios with hand-derived expectations,
// then randomized stimulus checked against a cycle-level reference model.
module tb_game_tick_scheduler;

  localparam int unsigned W = 16;

  logic         cin;
  logic         rst;
  logic         start, pause, stop;
  logic         cfg_valid;
  logic [1:0]   cfg_sel;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic [3:0]   tick, sq;
  logic [1:0]   state;

  int n_total = 0;
  int n_bad   = 0;

  game_tick_scheduler #(
    .W    (W),
    .DIV0 (4),
    .DIV1 (3),
    .DIV2 (5),
    .DIV3 (6)
  ) dut (
    .cin       (cin),
    .reset     (rst),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_sel   (cfg_sel),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .tick      (tick),
    .sq        (sq),
    .state     (state)
  );

  initial cin = 1'b0;
  always #5 cin = ~cin;

  // Reference model: 0 idle, 1 run, 2 pause; m_prog = run edges since last tick/clear.
  int unsigned m_state;
  int unsigned m_div  [4];
  int unsigned m_prog [4];
  logic [3:0]  m_tick, m_sq;
  bit          m_pv;
  int unsigned m_psel, m_pdiv;

  function automatic int unsigned reset_div(int i);
    case (i)
      0:       return 4;
      1:       return 3;
      2:       return 5;
      default: return 6;
    endcase
  endfunction

  task automatic model_edge();
    int unsigned nxt;
    int unsigned period;
    bit          due [4];
    bit          was_ready;
    if (rst) begin
      m_state = 0;
      for (int i = 0; i < 4; i++) begin
        m_div[i]  = reset_div(i);
        m_prog[i] = 0;
      end
      m_tick = '0;
      m_sq   = '0;
      m_pv   = 0;
      return;
    end
    if (stop)                          nxt = 0;
    else if (pause)                    nxt = (m_state == 1) ? 2 : m_state;
    else if (start && m_state != 1)    nxt = 1;
    else                               nxt = m_state;
    was_ready = !m_pv;
    for (int i = 0; i < 4; i++) begin
      period = (m_div[i] == 0) ? 1 : m_div[i];
      due[i] = (m_state == 1) && (m_prog[i] + 1 >= period);
      m_tick[i] = 1'b0;
      if (m_state == 1) begin
        if (due[i]) begin
          m_tick[i] = 1'b1;
          m_sq[i]   = ~m_sq[i];
          m_prog[i] = 0;
        end else begin
          m_prog[i] = m_prog[i] + 1;
        end
      end else if (m_state == 0) begin
        m_sq[i]   = 1'b0;
        m_prog[i] = 0;
      end
    end
    if (m_pv) begin
      if (stop || pause || m_state != 1) begin
        m_div[m_psel]  = m_pdiv;
        m_prog[m_psel] = 0;
        m_pv           = 0;
      end else if (due[m_psel]) begin
        m_div[m_psel] = m_pdiv;
        m_pv          = 0;
      end
    end
    if (cfg_valid && was_ready) begin
      if (m_state == 1) begin
        m_pv   = 1;
        m_psel = cfg_sel;
        m_pdiv = cfg_div;
      end else begin
        m_div[cfg_sel]  = cfg_div;
        m_prog[cfg_sel] = 0;
      end
    end
    if (stop) begin
      for (int i = 0; i < 4; i++) m_prog[i] = 0;
      m_tick = '0;
      m_sq   = '0;
    end
    m_state = nxt;
  endtask

  // One clock: advance the model on the edge, then settle before sampling.
  task automatic step();
    @(posedge cin);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; start = 0; pause = 0; stop = 0;
    cfg_valid = 0; cfg_sel = '0; cfg_div = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; start = 1; cfg_valid = 1; cfg_sel = 2'd1; cfg_div = 16'd9;
    step();
    clear_inputs();
    n_total++; if (state !== 2'b00) begin n_bad++; $display("FAIL reset_state got=%b want=00", state); end
    n_total++; if (tick !== 4'b0) begin n_bad++; $display("FAIL reset_tick got=%b want=0000", tick); end
    n_total++; if (sq !== 4'b0) begin n_bad++; $display("FAIL reset_sq got=%b want=0000", sq); end
    n_total++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", cfg_ready); end
  endtask

  task automatic test_basic_ticks();
    do_reset();
    start = 1;
    step();
    n_total++; if (state !== 2'b01) begin n_bad++; $display("FAIL basic_enter_run got=%b want=01", state); end
    for (int k = 1; k <= 12; k++) begin
      step();
      n_total++;
      if (tick[0] !== (k % 4 == 0)) begin
        n_bad++; $display("FAIL basic_tick0 k=%0d got=%b want=%b", k, tick[0], (k % 4 == 0));
      end
      n_total++;
      if (sq[0] !== 1'((k / 4) % 2)) begin
        n_bad++; $display("FAIL basic_sq0 k=%0d got=%b want=%b", k, sq[0], 1'((k / 4) % 2));
      end
      n_total++;
      if (tick[1] !== (k % 3 == 0)) begin
        n_bad++; $display("FAIL basic_tick1 k=%0d got=%b want=%b", k, tick[1], (k % 3 == 0));
      end
    end
    start = 0; stop = 1;
    step();
    stop = 0;
    n_total++;
    if ({state, tick, sq} !== 10'b0) begin
      n_bad++; $display("FAIL basic_stop got=%b/%b/%b want=00/0000/0000", state, tick, sq);
    end
  endtask

  task automatic test_pause();
    do_reset();
    start = 1;
    step();
    start = 0;
    for (int k = 1; k <= 2; k++) begin
      step();
      n_total++; if (tick[0] !== 1'b0) begin n_bad++; $display("FAIL pause_pre k=%0d got=%b want=0", k, tick[0]); end
    end
    pause = 1;
    for (int k = 3; k <= 12; k++) begin
      step();
      n_total++; if (state !== 2'b10) begin n_bad++; $display("FAIL pause_state k=%0d got=%b want=10", k, state); end
      n_total++; if (tick[0] !== 1'b0) begin n_bad++; $display("FAIL pause_tick0 k=%0d got=%b want=0", k, tick[0]); end
      if (k >= 4) begin
        n_total++; if (tick !== 4'b0) begin n_bad++; $display("FAIL pause_no_tick k=%0d got=%b want=0000", k, tick); end
      end
    end
    pause = 0; start = 1;
    step();
    n_total++; if (state !== 2'b01) begin n_bad++; $display("FAIL pause_resume got=%b want=01", state); end
    start = 0;
    for (int k = 14; k <= 18; k++) begin
      step();
      n_total++;
      if (tick[0] !== (k == 14 || k == 18)) begin
        n_bad++; $display("FAIL pause_delayed k=%0d got=%b want=%b", k, tick[0], (k == 14 || k == 18));
      end
    end
  endtask

  task automatic test_cfg_run();
    do_reset();
    start = 1;
    step();
    start = 0;
    step();
    cfg_valid = 1; cfg_sel = 2'd0; cfg_div = 16'd2;
    step();
    n_total++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL cfg_pending_ready got=%b want=0", cfg_ready); end
    cfg_sel = 2'd1; cfg_div = 16'd1;
    step();
    n_total++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL cfg_stall_ready got=%b want=0", cfg_ready); end
    n_total++; if (tick[0] !== 1'b0) begin n_bad++; $display("FAIL cfg_k3_tick0 got=%b want=0", tick[0]); end
    step();
    n_total++; if (tick[0] !== 1'b1) begin n_bad++; $display("FAIL cfg_old_period got=%b want=1", tick[0]); end
    n_total++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL cfg_ready_back got=%b want=1", cfg_ready); end
    cfg_valid = 0;
    for (int k = 5; k <= 10; k++) begin
      step();
      n_total++;
      if (tick[0] !== (k % 2 == 0)) begin
        n_bad++; $display("FAIL cfg_new_period k=%0d got=%b want=%b", k, tick[0], (k % 2 == 0));
      end
      n_total++;
      if (tick[1] !== (k % 3 == 0)) begin
        n_bad++; $display("FAIL cfg_stalled_write k=%0d got=%b want=%b", k, tick[1], (k % 3 == 0));
      end
    end
  endtask

  task automatic test_zero_div();
    do_reset();
    cfg_valid = 1; cfg_sel = 2'd1; cfg_div = 16'd0;
    step();
    n_total++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL zero_idle_ready got=%b want=1", cfg_ready); end
    cfg_valid = 0; start = 1;
    step();
    start = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_total++; if (tick[1] !== 1'b1) begin n_bad++; $display("FAIL zero_tick1 k=%0d got=%b want=1", k, tick[1]); end
      n_total++;
      if (sq[1] !== 1'(k % 2)) begin
        n_bad++; $display("FAIL zero_sq1 k=%0d got=%b want=%b", k, sq[1], 1'(k % 2));
      end
    end
  endtask

  task automatic test_stop_priority();
    do_reset();
    start = 1;
    for (int k = 0; k <= 4; k++) step();
    cfg_valid = 1; cfg_sel = 2'd2; cfg_div = 16'd2;
    step();
    n_total++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL prio_pending got=%b want=0", cfg_ready); end
    n_total++; if (sq !== 4'b0111) begin n_bad++; $display("FAIL prio_sq_before got=%b want=0111", sq); end
    cfg_valid = 0; stop = 1; pause = 1; start = 1;
    step();
    n_total++;
    if ({state, tick, sq} !== 10'b0) begin
      n_bad++; $display("FAIL prio_cleared got=%b/%b/%b want=00/0000/0000", state, tick, sq);
    end
    n_total++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL prio_ready got=%b want=1", cfg_ready); end
    stop = 0; pause = 0;
    step();
    start = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_total++;
      if (tick[2] !== (k % 2 == 0)) begin
        n_bad++; $display("FAIL prio_applied k=%0d got=%b want=%b", k, tick[2], (k % 2 == 0));
      end
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    cfg_valid = 1; cfg_sel = 2'd0; cfg_div = 16'd2;
    step();
    cfg_valid = 0; start = 1;
    step();
    step();
    cfg_valid = 1; cfg_sel = 2'd3; cfg_div = 16'd1;
    step();
    n_total++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL rstp_pending got=%b want=0", cfg_ready); end
    rst = 1;
    step();
    rst = 0; cfg_valid = 0;
    n_total++; if (state !== 2'b00) begin n_bad++; $display("FAIL rstp_state got=%b want=00", state); end
    n_total++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rstp_ready got=%b want=1", cfg_ready); end
    n_total++;
    if ({tick, sq} !== 8'b0) begin n_bad++; $display("FAIL rstp_outputs got=%b/%b want=0000/0000", tick, sq); end
    step();
    start = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_total++;
      if (tick[0] !== (k == 4)) begin
        n_bad++; $display("FAIL rstp_div0 k=%0d got=%b want=%b", k, tick[0], (k == 4));
      end
      n_total++;
      if (tick[3] !== (k == 6)) begin
        n_bad++; $display("FAIL rstp_div3 k=%0d got=%b want=%b", k, tick[3], (k == 6));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 499) == 0);
      stop      = ($urandom_range(0, 99) < 3);
      pause     = ($urandom_range(0, 99) < 8);
      start     = ($urandom_range(0, 99) < 30);
      cfg_valid = ($urandom_range(0, 99) < 15);
      cfg_sel   = 2'($urandom_range(0, 3));
      cfg_div   = 16'($urandom_range(0, 6));
      step();
      n_total++;
      if (tick !== m_tick) begin n_bad++; $display("FAIL rand_tick c=%0d got=%b want=%b", c, tick, m_tick); end
      n_total++;
      if (sq !== m_sq) begin n_bad++; $display("FAIL rand_sq c=%0d got=%b want=%b", c, sq, m_sq); end
      n_total++;
      if (state !== 2'(m_state)) begin
        n_bad++; $display("FAIL rand_state c=%0d got=%b want=%b", c, state, 2'(m_state));
      end
      n_total++;
      if (cfg_ready !== !m_pv) begin
        n_bad++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, cfg_ready, !m_pv);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    m_state = 0; m_tick = '0; m_sq = '0; m_pv = 0; m_psel = 0; m_pdiv = 0;
    for (int i = 0; i < 4; i++) begin
      m_div[i]  = reset_div(i);
      m_prog[i] = 0;
    end
    test_reset();
    test_basic_ticks();
    test_pause();
    test_cfg_run();
    test_zero_div();
    test_stop_priority();
    test_reset_pending();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/game_tick_scheduler.md
GAME_TICK_SCHEDULER -- requirements
Module: game_tick_scheduler

Interface
REQ-001 Parameter W, 32, width of divisor and counter fields.
REQ-002 Parameter DIV0, 833333, reset divisor for channel 0 (frame tick, 60 Hz at 50 MHz).
REQ-003 Parameter DIV1, 5000000, reset divisor for channel 1 (movement tick, 10 Hz).
REQ-004 Parameter DIV2, 25000000, reset divisor for channel 2 (blink, 2 Hz).
REQ-005 Parameter DIV3, 50000000, reset divisor for channel 3 (seconds tick, 1 Hz).
REQ-006 cin  input  1  single system clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  level; requests RUN.
REQ-009 pause  input  1  level; requests PAUSE.
REQ-010 stop  input  1  level; requests IDLE.
REQ-011 cfg_valid  input  1  divisor-write request.
REQ-012 cfg_sel  input  2  target channel of write.
REQ-013 cfg_div  input  W  new divisor value.
REQ-014 cfg_ready  output  1  write accepted on edge where cfg_valid && cfg_ready.
REQ-015 tick  output  4  per-channel one-cycle enable pulses, registered.
REQ-016 sq  output  4  per-channel square waves, toggled on each tick, registered.
REQ-017 state  output  2  00 IDLE, 01 RUN, 10 PAUSE.

Function
REQ-018 Each channel i SHALL hold divisor div[i] and counter cnt[i], both W bits.
REQ-019 Effective divisor SHALL be max(div[i],1); a divisor of 0 behaves as 1.
REQ-020 In RUN, on each edge: if cnt[i] >= eff_div[i]-1 then tick[i]<=1, sq[i]<=~sq[i], cnt[i]<=0; else tick[i]<=0, cnt[i]<=cnt[i]+1.
REQ-021 Tick period in RUN SHALL be exactly eff_div[i] cycles; first tick is registered at the eff_div[i]-th edge after entering RUN from IDLE.
REQ-022 In IDLE: cnt all 0, tick all 0, sq all 0.
REQ-023 In PAUSE: cnt and sq hold, tick all 0; resuming continues from held counts (no phase loss).
REQ-024 Transitions, priority stop > pause > start: any->IDLE on stop; RUN->PAUSE on pause; IDLE->RUN and PAUSE->RUN on start with pause and stop low; otherwise hold.
REQ-025 The state change takes effect on the sampling edge; counters follow the new state from the next edge.
REQ-026 Entering IDLE SHALL clear cnt, tick and sq on that same edge.
REQ-027 A single pending-update slot (pend_valid, pend_sel, pend_div) SHALL exist; cfg_ready = ~pend_valid.
REQ-028 A write accepted in IDLE or PAUSE SHALL update div[cfg_sel] on the accepting edge and clear that channel's cnt; pend_valid stays 0.
REQ-029 A write accepted in RUN SHALL set pend_valid; div is unchanged until the target channel's next tick edge, at which div[pend_sel]<=pend_div and pend_valid<=0 (tick still issues under the old divisor).
REQ-030 If stop or pause arrives while pend_valid=1, the pending value SHALL be applied on that same edge, the target cnt cleared, and pend_valid cleared.
REQ-031 A write accepted on an edge where the state also changes SHALL be handled by the rules for the state the block is leaving.
REQ-032 Counters SHALL not overflow: compare-and-clear precedes increment; no wrap beyond eff_div-1.

Reset
REQ-033 On reset: state=IDLE, div[0..3]=DIV0..DIV3, cnt=0, tick=0, sq=0, pend_valid=0, cfg_ready=1.
REQ-034 Reset SHALL override all other inputs, including mid-RUN and with a pending update.

Verification
REQ-035 DIV0=4: reset, start=1 -> tick[0] high at edges 4, 8, 12 after RUN entry; sq[0] toggles each tick.
REQ-036 RUN with div0=4; pause after 2 counts for 10 cycles, then start -> tick[0] delayed exactly 10 cycles; no ticks during PAUSE.
REQ-037 RUN, write cfg_sel=0 cfg_div=2 mid-period -> cfg_ready low until next tick[0]; that tick at old period, subsequent ticks every 2 cycles; second write during pending is stalled.
REQ-038 IDLE, write cfg_div=0 to channel 1, start -> tick[1] high every cycle.
REQ-039 stop and pause and start all high in RUN -> IDLE, outputs cleared; pending update applied.
REQ-040 Assert reset mid-RUN with pend_valid=1 -> all div return to DIV0..DIV3, state=00, cfg_ready=1 next cycle.
